// File: rtl/srd_digitized_pkg.sv
// rtl/srd_digitized_pkg.sv - shared FSM states and width helper for the digit-serial divider
package srd_digitized_pkg;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_RUN    = 3'd1,
    ST_WAIT   = 3'd2,
    ST_OFFSET = 3'd3,
    ST_RST    = 3'd4,
    ST_DONE   = 3'd5
  } state_t;

  function automatic int clog2(input int v);
    int w;
    w = 0;
    while ((1 << w) < v) w++;
    return w;
  endfunction

endpackage

// File: rtl/srd_digitized_div_unit.sv
// rtl/srd_digitized_div_unit.sv - one restoring-division digit, one dividend bit per cycle
module div_unit
  import srd_digitized_pkg::*;
#(
  parameter int SIZEB         = 1024,
  parameter int SIZEOF_DIGITS = 256
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     local_rst,
  input  logic [SIZEOF_DIGITS-1:0] d,
  input  logic [SIZEB-1:0]         r_in,
  input  logic [SIZEB-1:0]         b,
  input  logic                     digit_div_start,
  output logic [SIZEOF_DIGITS-1:0] q_digit,
  output logic [SIZEB-1:0]         r_out,
  output logic                     digit_div_done
);

  localparam int CNTW = clog2(SIZEOF_DIGITS + 1);

  logic [SIZEB-1:0]         rem;
  logic [SIZEOF_DIGITS-1:0] quo;
  logic [SIZEOF_DIGITS-1:0] dsh;
  logic [CNTW-1:0]          cnt;
  logic                     active;

  logic [SIZEB-1:0] cur_r;
  logic             cur_bit;
  logic [SIZEB:0]   rr;
  logic             ge;
  logic [SIZEB-1:0] nr;

  // The first step works straight off the inputs so no load cycle is spent.
  always_comb begin
    cur_r   = active ? rem : r_in;
    cur_bit = active ? dsh[SIZEOF_DIGITS-1] : d[SIZEOF_DIGITS-1];
    rr      = {cur_r, cur_bit};
    ge      = (rr >= {1'b0, b});
    nr      = ge ? SIZEB'(rr - {1'b0, b}) : rr[SIZEB-1:0];
  end

  always_ff @(posedge clk) begin
    if (rst || local_rst) begin
      rem            <= '0;
      quo            <= '0;
      dsh            <= '0;
      cnt            <= '0;
      active         <= 1'b0;
      digit_div_done <= 1'b0;
    end else if (active) begin
      rem <= nr;
      quo <= (quo << 1) | SIZEOF_DIGITS'(ge);
      dsh <= dsh << 1;
      cnt <= cnt + 1'b1;
      if (cnt == CNTW'(SIZEOF_DIGITS - 1)) begin
        active         <= 1'b0;
        digit_div_done <= 1'b1;
      end
    end else if (digit_div_start && !digit_div_done) begin
      rem            <= nr;
      quo            <= SIZEOF_DIGITS'(ge);
      dsh            <= d << 1;
      cnt            <= CNTW'(1);
      active         <= (SIZEOF_DIGITS > 1);
      digit_div_done <= (SIZEOF_DIGITS == 1);
    end
  end

  assign q_digit = quo;
  assign r_out   = rem;

endmodule

// File: rtl/srd_digitized.sv
// rtl/srd_digitized.sv - digit-serial restoring divider, MSB quotient digit first
module srd_digitized
  import srd_digitized_pkg::*;
#(
  parameter int SIZEA         = 1024,
  parameter int SIZEB         = 1024,
  parameter int SIZEOF_DIGITS = 256,
  parameter int DIGITS        = SIZEA / SIZEOF_DIGITS
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic [SIZEA-1:0] a,
  input  logic [SIZEB-1:0] b,
  output logic [SIZEA-1:0] q,
  output logic [SIZEB-1:0] r,
  output logic             busy,
  output logic             done,
  output logic             div_by_zero
);

  localparam int IDXW = (DIGITS > 1) ? clog2(DIGITS) : 1;

  state_t state, state_n;
  logic [IDXW-1:0]  idx, idx_n;
  logic [SIZEA-1:0] a_lat, a_lat_n;
  logic [SIZEB-1:0] b_lat, b_lat_n;
  logic [SIZEB-1:0] prem, prem_n;
  logic             sub_start, sub_start_n;
  logic             local_rst, local_rst_n;
  logic [SIZEA-1:0] q_n;
  logic [SIZEB-1:0] r_n;
  logic             busy_n, done_n, dbz_n;

  logic [SIZEOF_DIGITS-1:0] digit_in;
  logic [SIZEOF_DIGITS-1:0] q_digit;
  logic [SIZEB-1:0]         r_out;
  logic                     dig_done;

  assign digit_in = a_lat[idx*SIZEOF_DIGITS +: SIZEOF_DIGITS];

  div_unit #(
    .SIZEB        (SIZEB),
    .SIZEOF_DIGITS(SIZEOF_DIGITS)
  ) u_div (
    .clk            (clk),
    .rst            (rst),
    .local_rst      (local_rst),
    .d              (digit_in),
    .r_in           (prem),
    .b              (b_lat),
    .digit_div_start(sub_start),
    .q_digit        (q_digit),
    .r_out          (r_out),
    .digit_div_done (dig_done)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= ST_IDLE;
      idx         <= '0;
      a_lat       <= '0;
      b_lat       <= '0;
      prem        <= '0;
      sub_start   <= 1'b0;
      local_rst   <= 1'b0;
      q           <= '0;
      r           <= '0;
      busy        <= 1'b0;
      done        <= 1'b0;
      div_by_zero <= 1'b0;
    end else begin
      state       <= state_n;
      idx         <= idx_n;
      a_lat       <= a_lat_n;
      b_lat       <= b_lat_n;
      prem        <= prem_n;
      sub_start   <= sub_start_n;
      local_rst   <= local_rst_n;
      q           <= q_n;
      r           <= r_n;
      busy        <= busy_n;
      done        <= done_n;
      div_by_zero <= dbz_n;
    end
  end

  always_comb begin
    state_n     = state;
    idx_n       = idx;
    a_lat_n     = a_lat;
    b_lat_n     = b_lat;
    prem_n      = prem;
    sub_start_n = sub_start;
    local_rst_n = 1'b0;
    q_n         = q;
    r_n         = r;
    busy_n      = busy;
    done_n      = 1'b0;
    dbz_n       = div_by_zero;
    case (state)
      ST_IDLE: begin
        if (start) begin
          a_lat_n = a;
          b_lat_n = b;
          busy_n  = 1'b1;
          q_n     = '0;
          dbz_n   = 1'b0;
          if (b == '0) begin
            q_n     = '1;
            r_n     = SIZEB'(a);
            dbz_n   = 1'b1;
            state_n = ST_DONE;
          end else begin
            prem_n  = '0;
            idx_n   = IDXW'(DIGITS - 1);
            state_n = ST_RUN;
          end
        end
      end
      ST_RUN: begin
        sub_start_n = 1'b1;
        state_n     = ST_WAIT;
      end
      ST_WAIT: begin
        if (dig_done) state_n = ST_OFFSET;
      end
      ST_OFFSET: begin
        q_n[idx*SIZEOF_DIGITS +: SIZEOF_DIGITS] = q_digit;
        prem_n      = r_out;
        sub_start_n = 1'b0;
        local_rst_n = 1'b1;
        state_n     = ST_RST;
      end
      ST_RST: begin
        if (idx == '0) begin
          r_n     = prem;
          done_n  = 1'b1;
          busy_n  = 1'b0;
          state_n = ST_DONE;
        end else begin
          idx_n   = idx - 1'b1;
          state_n = ST_RUN;
        end
      end
      ST_DONE: begin
        // Divide-by-zero arrives here without done set; hold one extra cycle to raise it.
        if (done) begin
          state_n = ST_IDLE;
        end else begin
          done_n = 1'b1;
          busy_n = 1'b0;
        end
      end
      default: state_n = ST_IDLE;
    endcase
  end

endmodule
